// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe elastic register pipeline.
//   DEF_WIDTH / DEF_DEPTH : default data width and stage count
//   cnt_w(depth)          : bit width needed to count 0..depth valid stages
package dff_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register.
// The stage is ready when it is empty or when its downstream neighbour is ready,
// so bubbles collapse through the chain without waiting for the output.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   flush      : synchronous clear of valid and data
//   up_valid   : upstream stage (or input) holds valid data
//   up_data    : upstream data
//   down_ready : downstream stage (or consumer) can take this stage's word
//   ready      : this stage loads on the next edge
//   valid      : this stage holds valid data
//   data       : this stage's data
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  assign ready = ~valid | down_ready;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would shoot a word through
  // several stages in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (ready) begin
      valid <= up_valid;
      // Data only moves with a valid word, so bubbles never toggle the bus.
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit flops with
// per-stage valid bits, valid/ready handshake, bubble collapsing and a
// synchronous flush. Stage 0 faces the producer, stage DEPTH-1 the consumer.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   flush      : synchronous clear of all stages (no input taken that cycle)
//   in_valid   : upstream data valid
//   in_data    : upstream data
//   in_ready   : pipeline accepts in_data this cycle
//   out_valid  : last stage holds valid data
//   out_data   : last stage data
//   out_ready  : consumer accepts out_data this cycle
//   occupancy  : number of valid stages, 0..DEPTH
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   occupancy
);

  localparam int CW = cnt_w(DEPTH);

  logic          xfer_in;
  logic          xfer_out;
  logic [CW-1:0] occupancy_next;

  // Each stage keeps its own handshake signals; neighbours are reached by
  // constant-index references so the ready chain is a plain combinational path.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             down_ready;
    logic             rdy;
    logic             v;
    logic [WIDTH-1:0] d;

    if (k == 0) begin : g_head
      assign up_valid = xfer_in;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = g_stage[k-1].v;
      assign up_data  = g_stage[k-1].d;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_link
      assign down_ready = g_stage[k+1].rdy;
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (down_ready),
      .ready      (rdy),
      .valid      (v),
      .data       (d)
    );
  end

  // Flush blocks the input so a word presented during flush is never taken.
  assign in_ready  = g_stage[0].rdy & ~flush;
  assign xfer_in   = in_valid & in_ready;
  assign out_valid = g_stage[DEPTH-1].v;
  assign out_data  = g_stage[DEPTH-1].d;
  assign xfer_out  = out_valid & out_ready;

  // NOTE: every combinational output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    occupancy_next = occupancy;
    unique case ({xfer_in, xfer_out})
      2'b10:   occupancy_next = occupancy + CW'(1);
      2'b01:   occupancy_next = occupancy - CW'(1);
      default: occupancy_next = occupancy;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy_next;
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed and randomised bench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VAL=0).
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #1 rst = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    step();
    step();
    #1 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [1:0] occ_e [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic       ov_e  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] od_e  [7] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        in_valid = 1'b1;
        in_data  = words[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", c, in_ready); end
      end
      step();
      checks++; if (occupancy !== occ_e[c]) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want %0d", c, occupancy, occ_e[c]); end
      checks++; if (out_valid !== ov_e[c]) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", c, out_valid, ov_e[c]); end
      if (ov_e[c]) begin
        checks++; if (out_data !== od_e[c]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", c, out_data, od_e[c]); end
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] drain [3] = '{8'hA2, 8'hA3, 8'hA4};
    idle();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hA1 + 8'(c);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b want 1", c, in_ready); end
      step();
    end
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL fill_occ: got %0d want 3", occupancy); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL fill_head: got %b/%h want 1/a1", out_valid, out_data); end
    in_valid = 1'b1;
    in_data  = 8'hA4;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    step();
    checks++; if (out_data !== 8'hA1 || occupancy !== 2'd3) begin errors++; $display("FAIL full_hold: got %h/%0d want a1/3", out_data, occupancy); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pass_in_ready: got %b want 1", in_ready); end
    step();
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL full_pass_occ: got %0d want 3", occupancy); end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== drain[i]) begin errors++; $display("FAIL fill_drain[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, drain[i]); end
      step();
    end
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got %0d/%b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_bubble();
    logic [7:0] drain [3] = '{8'h5A, 8'hB1, 8'hB2};
    idle();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    for (int e = 1; e < 3; e++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_early_valid[%0d]: got %b want 0", e, out_valid); end
      step();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL bubble_head: got %b/%h want 1/5a", out_valid, out_data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bubble_occ: got %0d want 1", occupancy); end
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hB1 + 8'(c);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready[%0d]: got %b want 1", c, in_ready); end
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd3 || out_data !== 8'h5A) begin errors++; $display("FAIL bubble_full: got %0d/%h want 3/5a", occupancy, out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_full_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) begin
        checks++; if (out_valid !== 1'b1 || out_data !== drain[i+1]) begin errors++; $display("FAIL bubble_drain[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, drain[i+1]); end
      end
    end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL bubble_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    idle();
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hC1 + 8'(c);
      step();
    end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_clear: got %b/%0d want 0/0", out_valid, occupancy); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL flush_data: got %h want 00", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_leak[%0d]: got %b/%0d want 0/0", i, out_valid, occupancy); end
    end
  endtask

  task automatic test_async_reset();
    logic ov_e [3] = '{1'b0, 1'b0, 1'b1};
    idle();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hD1 + 8'(c);
      step();
    end
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL areset_pre_occ: got %0d want 3", occupancy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL areset_now: got %b/%0d want 0/0", out_valid, occupancy); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL areset_data: got %h want 00", out_data); end
    #2 rst = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hC3;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      checks++; if (out_valid !== ov_e[e]) begin errors++; $display("FAIL areset_lat[%0d]: got %b want %b", e, out_valid, ov_e[e]); end
      if (e < 2) step();
    end
    checks++; if (out_data !== 8'hC3) begin errors++; $display("FAIL areset_word: got %h want c3", out_data); end
    step();
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       exp_ready;
    idle();
    for (int n = 0; n < 10000; n++) begin
      checks++; if (int'(occupancy) !== q.size()) begin errors++; $display("FAIL rand_occ[%0d]: got %0d want %0d", n, occupancy, q.size()); end
      if (prev_hold) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin errors++; $display("FAIL rand_stable[%0d]: got %b/%h want 1/%h", n, out_valid, out_data, prev_data); end
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      exp_ready = !(q.size() == DEPTH && !out_ready);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, exp_ready); end
      if (q.size() == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_empty_valid[%0d]: got %b want 0", n, out_valid); end
      end
      if (out_valid && out_ready && q.size() != 0) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, out_data, q[0]); end
        void'(q.pop_front());
      end
      if (in_valid && exp_ready) q.push_back(in_data);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      if (out_valid) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_drain[%0d]: got %h want %h", n, out_data, q[0]); end
        void'(q.pop_front());
      end
      step();
    end
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL rand_final: occ %0d valid %b left %0d want 0/0/0", occupancy, out_valid, q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
